note_sequencer: RTL and testbench

- Parametrised record/playback sequencer for the guitar front end.
- Record mode: once per beat, samples string and fret-bar activity into an internal note memory.
- Play mode: replays the stored notes to the audio path at the selected tempo, either once or looping.
- Replaces the fixed 6x5, 64-deep datapath and clock-divider pair with one block whose geometry, depth and clock rate are generic.

---
 rtl/sequencer_pkg.sv | 38 +++
 rtl/beat_timer.sv | 38 +++
 rtl/note_sequencer.sv | 166 ++++++++++++++++
 tb/tb_note_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sequencer_pkg.sv
// Shared types and helpers for the note record/playback sequencer.
package sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        PLAY   = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic int unsigned bpm_of(input logic [2:0] sel);
        int unsigned bpm;
        case (sel)
            3'd0:    bpm = 40;
            3'd1:    bpm = 60;
            3'd2:    bpm = 80;
            3'd3:    bpm = 100;
            3'd4:    bpm = 120;
            3'd5:    bpm = 140;
            3'd6:    bpm = 180;
            default: bpm = 220;
        endcase
        return bpm;
    endfunction

    function automatic int unsigned note_width(input int unsigned num_strings,
                                               input int unsigned num_frets);
        return num_strings * (num_frets + 1);
    endfunction

    // Bit position of string str at fret position pos in a one-hot note word.
    function automatic int unsigned note_index(input int unsigned num_strings,
                                               input int unsigned pos,
                                               input int unsigned str);
        return pos * num_strings + str;
    endfunction

endpackage

// File: rtl/beat_timer.sv
// Beat tick generator: counts down one tempo period per beat while run is high.
module beat_timer
    import sequencer_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50000000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_run,
    input  logic [2:0] i_speed,
    output logic       o_beat
);

    localparam longint unsigned MAX_PERIOD = (64'(CLK_HZ) * 64'd60) / 64'd40;
    localparam int unsigned     CW         = $clog2(MAX_PERIOD + 64'd1);

    function automatic logic [CW-1:0] period_m1(input logic [2:0] sel);
        longint unsigned period;
        period = (64'(CLK_HZ) * 64'd60) / 64'(bpm_of(sel));
        return CW'(period - 64'd1);
    endfunction

    logic [CW-1:0] r_cnt;

    // Held at period-1 while idle, so the first tick lands exactly one period after start.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (!i_run || r_cnt == '0) begin
            r_cnt <= period_m1(i_speed);
        end else begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_beat = i_run && (r_cnt == '0);

endmodule

// File: rtl/note_sequencer.sv
// Record/playback note sequencer: captures string/fret activity per beat, replays it at tempo.
module note_sequencer
    import sequencer_pkg::*;
#(
    parameter int unsigned NUM_STRINGS = 6,
    parameter int unsigned NUM_FRETS   = 4,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned CLK_HZ      = 50000000,
    localparam int unsigned NOTE_W     = note_width(NUM_STRINGS, NUM_FRETS),
    localparam int unsigned AW         = $clog2(DEPTH)
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic                   i_stop,
    input  logic                   i_mode,
    input  logic                   i_loop,
    input  logic [2:0]             i_speed,
    input  logic [NUM_STRINGS-1:0] i_strings,
    input  logic [NUM_FRETS-1:0]   i_frets,
    output logic [NOTE_W-1:0]      o_note_out,
    output logic                   o_note_valid,
    output logic                   o_beat,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [AW:0]            o_length,
    output logic                   o_full
);

    localparam int unsigned FW = $clog2(NUM_FRETS + 1);

    state_t               r_state, w_state_next;
    logic [AW-1:0]        r_wr_addr, r_rd_addr;
    logic [AW:0]          r_length;
    logic                 r_loop;
    logic [NUM_STRINGS-1:0] r_s_acc;
    logic [FW-1:0]        r_f_max;
    logic [NOTE_W-1:0]    r_mem [DEPTH];
    logic [NOTE_W-1:0]    r_note;
    logic                 r_note_valid;

    logic                 w_run, w_beat, w_wr_en, w_rd_en, w_rd_last;
    logic [FW-1:0]        w_high_fret, w_f_win;
    logic [NUM_STRINGS-1:0] w_s_win;
    logic [NOTE_W-1:0]    w_note_enc;

    assign w_run = (r_state == RECORD) || (r_state == PLAY);

    beat_timer #(
        .CLK_HZ (CLK_HZ)
    ) u_beat_timer (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_run   (w_run),
        .i_speed (i_speed),
        .o_beat  (w_beat)
    );

    // Window state including the current cycle, so a tick commits what is held right now.
    always_comb begin
        w_high_fret = '0;
        for (int f = 0; f < NUM_FRETS; f++) begin
            if (i_frets[f]) w_high_fret = FW'(f + 1);
        end
        w_f_win = (w_high_fret > r_f_max) ? w_high_fret : r_f_max;
        w_s_win = r_s_acc | i_strings;
        w_note_enc = '0;
        for (int p = 0; p <= NUM_FRETS; p++) begin
            for (int s = 0; s < NUM_STRINGS; s++) begin
                if (w_f_win == FW'(p) && w_s_win[s]) begin
                    w_note_enc[note_index(NUM_STRINGS, p, s)] = 1'b1;
                end
            end
        end
    end

    assign w_rd_last = (({1'b0, r_rd_addr} + (AW + 1)'(1)) == r_length);

    always_comb begin
        w_state_next = r_state;
        w_wr_en      = 1'b0;
        w_rd_en      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    if (i_mode)              w_state_next = RECORD;
                    else if (r_length == '0) w_state_next = DONE;
                    else                     w_state_next = PLAY;
                end
            end
            RECORD: begin
                if (i_stop) begin
                    w_state_next = DONE;
                end else if (w_beat) begin
                    w_wr_en = 1'b1;
                    if (r_wr_addr == AW'(DEPTH - 1)) w_state_next = DONE;
                end
            end
            PLAY: begin
                if (i_stop) begin
                    w_state_next = DONE;
                end else if (w_beat) begin
                    w_rd_en = 1'b1;
                    if (w_rd_last && !r_loop) w_state_next = DONE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_wr_addr    <= '0;
            r_rd_addr    <= '0;
            r_length     <= '0;
            r_loop       <= 1'b0;
            r_s_acc      <= '0;
            r_f_max      <= '0;
            r_note       <= '0;
            r_note_valid <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_note_valid <= w_rd_en;
            if (r_state == IDLE && i_start) begin
                r_loop    <= i_loop;
                r_rd_addr <= '0;
                if (i_mode) begin
                    r_wr_addr <= '0;
                    r_length  <= '0;
                end
            end
            // A tick or stop closes the window; anything else keeps accumulating.
            if (r_state == RECORD && !i_stop && !w_beat) begin
                r_s_acc <= w_s_win;
                r_f_max <= w_f_win;
            end else begin
                r_s_acc <= '0;
                r_f_max <= '0;
            end
            if (w_wr_en) begin
                r_wr_addr <= r_wr_addr + AW'(1);
                r_length  <= {1'b0, r_wr_addr} + (AW + 1)'(1);
            end
            if (w_rd_en) begin
                r_rd_addr <= w_rd_last ? '0 : r_rd_addr + AW'(1);
                r_note    <= r_mem[r_rd_addr];
            end else if (r_state == DONE) begin
                r_note <= '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_en) r_mem[r_wr_addr] <= w_note_enc;
    end

    assign o_note_out   = r_note;
    assign o_note_valid = r_note_valid;
    assign o_beat       = w_beat;
    assign o_busy       = w_run;
    assign o_done       = (r_state == DONE);
    assign o_length     = r_length;
    assign o_full       = (r_length == (AW + 1)'(DEPTH));

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: 120 Hz clock model, depth 4, 6 strings x 4 frets.
module tb_note_sequencer;

    localparam int unsigned NS     = 6;
    localparam int unsigned NF     = 4;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CLK_HZ = 120;
    localparam int unsigned NOTE_W = NS * (NF + 1);
    localparam int unsigned AW     = 2;

    logic              clk;
    logic              rst;
    logic              start, stop, mode, loop_en;
    logic [2:0]        speed;
    logic [NS-1:0]     strings;
    logic [NF-1:0]     frets;
    logic [NOTE_W-1:0] note_out;
    logic              note_valid, beat, busy, done, full;
    logic [AW:0]       length;

    int checks   = 0;
    int failures = 0;
    logic [NOTE_W-1:0] exp_q[$];

    note_sequencer #(
        .NUM_STRINGS (NS),
        .NUM_FRETS   (NF),
        .DEPTH       (DEPTH),
        .CLK_HZ      (CLK_HZ)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_start      (start),
        .i_stop       (stop),
        .i_mode       (mode),
        .i_loop       (loop_en),
        .i_speed      (speed),
        .i_strings    (strings),
        .i_frets      (frets),
        .o_note_out   (note_out),
        .o_note_valid (note_valid),
        .o_beat       (beat),
        .o_busy       (busy),
        .o_done       (done),
        .o_length     (length),
        .o_full       (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // Monitor: every note_valid must match the oldest expected note.
    always @(negedge clk) begin
        if (!rst && note_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_note: got 0x%0h expected none", note_out);
            end else begin
                check("note_out", note_out, exp_q.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic m, input logic lp);
        mode    = m;
        loop_en = lp;
        start   = 1'b1;
        cyc();
        start   = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
    endtask

    // Returns inside the tick cycle.
    task automatic wait_beat();
        for (int i = 0; i < 200; i++) begin
            if (beat) return;
            cyc();
        end
        timeout("wait_beat");
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (done) return;
            cyc();
        end
        timeout("wait_done");
    endtask

    task automatic wait_drain(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (exp_q.size() == 0) return;
            cyc();
        end
        timeout("wait_drain");
    endtask

    initial begin
        int beats[$];
        rst = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; loop_en = 1'b0;
        speed = 3'd4; strings = '0; frets = '0;
        #1 rst = 1'b1;
        repeat (3) cyc();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_note", {note_valid, note_out}, 0);
        check("rst_length", length, 0);
        check("rst_full_beat", {full, beat}, 0);
        rst = 1'b0;

        // Tick timing: 120 Hz, 120 BPM -> period 60.
        pulse_start(1'b1, 1'b0);
        check("busy_cycle1", busy, 1);
        for (int k = 1; k <= 181; k++) begin
            if (beat) beats.push_back(k);
            cyc();
        end
        check("beat_count", beats.size(), 3);
        for (int i = 0; i < 3; i++) check("beat_cycle", beats[i], 60 * (i + 1));
        pulse_stop();
        check("t1_done", done, 1);
        check("t1_length", length, 3);
        cyc();

        // Record two windows then play once.
        pulse_start(1'b1, 1'b0);
        strings = 6'b000100; frets = 4'b0100;
        wait_beat();
        cyc();
        strings = 6'b000001; frets = 4'b0000;
        wait_beat();
        cyc();
        strings = '0;
        pulse_stop();
        check("t2_rec_length", length, 2);
        cyc();
        exp_q.push_back(NOTE_W'(1) << 20);
        exp_q.push_back(NOTE_W'(1) << 0);
        pulse_start(1'b0, 1'b0);
        wait_done(300);
        cyc();
        check("t2_drained", exp_q.size(), 0);
        check("t2_note_cleared", note_out, 0);
        check("t2_length", length, 2);

        // Accumulation: highest fret in the window applies to every string plucked.
        pulse_start(1'b1, 1'b0);
        repeat (3) cyc();
        strings = 6'b000010; frets = 4'b0001;
        repeat (2) cyc();
        strings = '0; frets = '0;
        repeat (5) cyc();
        strings = 6'b100000; frets = 4'b0100;
        repeat (2) cyc();
        strings = '0; frets = '0;
        wait_beat();
        cyc();
        pulse_stop();
        cyc();
        check("t3_length", length, 1);
        exp_q.push_back((NOTE_W'(1) << 19) | (NOTE_W'(1) << 23));
        pulse_start(1'b0, 1'b0);
        wait_done(200);
        cyc();
        check("t3_drained", exp_q.size(), 0);

        // Fill to depth without stop, then loop playback.
        pulse_start(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            strings = NS'(1) << i;
            wait_beat();
            cyc();
        end
        strings = '0;
        check("t4_done", done, 1);
        check("t4_full", full, 1);
        check("t4_length", length, 4);
        cyc();
        for (int i = 0; i < 6; i++) exp_q.push_back(NOTE_W'(1) << (i % 4));
        pulse_start(1'b0, 1'b1);
        pulse_start(1'b1, 1'b0);
        check("t4_start_ignored_busy", busy, 1);
        check("t4_start_ignored_len", length, 4);
        wait_drain(500);
        // Stop on the tick cycle: no further note may appear.
        wait_beat();
        pulse_stop();
        check("t4_stop_done", done, 1);
        cyc();
        check("t4_note_cleared", note_out, 0);

        // Stop coincident with a record tick: nothing written.
        pulse_start(1'b1, 1'b0);
        strings = 6'b000001;
        wait_beat();
        pulse_stop();
        strings = '0;
        check("t5_done", done, 1);
        check("t5_length", length, 0);
        cyc();
        pulse_start(1'b0, 1'b0);
        check("t5_empty_play_done", done, 1);
        check("t5_empty_play_busy", busy, 0);
        repeat (3) cyc();

        // Reset during play.
        pulse_start(1'b1, 1'b0);
        strings = 6'b001000; frets = 4'b1000;
        wait_beat();
        cyc();
        strings = '0; frets = '0;
        pulse_stop();
        cyc();
        exp_q.push_back(NOTE_W'(1) << 27);
        pulse_start(1'b0, 1'b1);
        wait_drain(200);
        repeat (5) cyc();
        check("t6_busy_before", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_note", {note_valid, note_out}, 0);
        check("t6_rst_length", length, 0);
        check("t6_rst_done", done, 0);
        cyc();
        rst = 1'b0;
        pulse_start(1'b0, 1'b0);
        check("t6_empty_done", done, 1);
        cyc();
        check("final_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
